mux_select_sequencer: RTL and testbench

MUX_SELECT_SEQUENCER -- requirements
Module: mux_select_sequencer

---
 rtl/mux_select_sequencer.sv | 136 +++++++++++++
 tb/tb_mux_select_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - scans a 4:1 mux select across channels, holding each for max(dwell,1) cycles
// Build option: SEQ_SKIP_MASKED_EN skips channels whose mask bit is 0 instead of dwelling on them with EN=0.
module mux_select_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] mask,
  input  logic [7:0] dwell,
  output logic [1:0] S,
  output logic       EN,
  output logic       busy,
  output logic       wrap
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       wrap_q, wrap_d;

  logic [7:0] dwell_m1;
  logic [1:0] first_ch;
  logic [1:0] next_ch;

`ifdef SEQ_SKIP_MASKED_EN
  // Lowest enabled channel; only meaningful when m != 0.
  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] f;
    f = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) f = 2'(i);
    end
    return f;
  endfunction

  // Next enabled channel cyclically above cur; falls back to cur when it is the only one enabled.
  function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] c;
    logic [1:0] n;
    n = cur;
    for (int k = 3; k >= 1; k--) begin
      c = cur + 2'(k);
      if (m[c]) n = c;
    end
    return n;
  endfunction
`endif

  always_comb begin
    dwell_m1 = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;
`ifdef SEQ_SKIP_MASKED_EN
    first_ch = first_set(mask);
    next_ch  = next_set(sel_q, mask);
`else
    first_ch = 2'd0;
    next_ch  = sel_q + 2'd1;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop && (mask != 4'd0)) begin
          state_d = SCAN;
          sel_d   = first_ch;
          cnt_d   = dwell_m1;
          en_d    = mask[first_ch];
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (mask == 4'd0) begin
          // Nothing left to scan: drop out quietly, select held.
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          sel_d  = next_ch;
          cnt_d  = dwell_m1;
          en_d   = mask[next_ch];
          wrap_d = (next_ch < sel_q);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign S    = sel_q;
  assign EN   = en_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - directed self-checking bench for mux_select_sequencer
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic [1:0] S;
  logic       EN;
  logic       busy;
  logic       wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_select_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mask  (mask),
    .dwell (dwell),
    .S     (S),
    .EN    (EN),
    .busy  (busy),
    .wrap  (wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] es, input logic ee,
                     input logic eb, input logic ew);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {S, EN, busy, wrap};
    exp = {es, ee, eb, ew};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s S/EN/busy/wrap observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic ee, input logic eb, input logic ew);
    logic [2:0] obs;
    logic [2:0] exp;
    obs = {EN, busy, wrap};
    exp = {ee, eb, ew};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s EN/busy/wrap observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] s_rr  [0:7];
    logic [1:0] s_d0  [0:7];
    logic [1:0] s_m5  [0:2];
    logic       e_m5  [0:2];
    logic       w_m5  [0:2];

    s_rr = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    s_d0 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef SEQ_SKIP_MASKED_EN
    s_m5 = '{2'd2, 2'd0, 2'd2};
    e_m5 = '{1'b1, 1'b1, 1'b1};
    w_m5 = '{1'b0, 1'b1, 1'b0};
`else
    s_m5 = '{2'd1, 2'd2, 2'd3};
    e_m5 = '{1'b0, 1'b1, 1'b0};
    w_m5 = '{1'b0, 1'b0, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; stop = 1'b0; mask = 4'h0; dwell = 8'd0;
    tick(); tick();
    chk("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 2'd0, 1'b0, 1'b0, 1'b0);

    // Full mask, dwell 2: each channel twice, wrap on return to 0.
    mask = 4'hF; dwell = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("rr_first", 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_step%0d", i), s_rr[i], 1'b1, 1'b1, (i == 7));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("rr_stop", 2'd0, 1'b0, 1'b0, 1'b0);

    mask = 4'h0; start = 1'b1;
    tick(); start = 1'b0;
    chk("mask0_start", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mask0_stay", 2'd0, 1'b0, 1'b0, 1'b0);

    mask = 4'b0101; dwell = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("m5_first", 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("m5_step%0d", i), s_m5[i], e_m5[i], 1'b1, w_m5[i]);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("m5_stop", s_m5[2], 1'b0, 1'b0, 1'b0);

    // dwell 0 behaves as 1.
    mask = 4'hF; dwell = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("d0_first", 2'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("d0_step%0d", i), s_d0[i], 1'b1, 1'b1, (i == 3) || (i == 7));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("d0_stop", 2'd0, 1'b0, 1'b0, 1'b0);

    mask = 4'hF; dwell = 8'd3; start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("d3_first", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("d3_hold1", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("d3_hold2", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("d3_adv", 2'd1, 1'b1, 1'b1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_scan", 2'd1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_mid", 2'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_in_idle", 2'd1, 1'b0, 1'b0, 1'b0);

    // Mask dropped to zero: scan ends at the next advance edge.
    mask = 4'hF; dwell = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("m0adv_first", 2'd0, 1'b1, 1'b1, 1'b0);
    mask = 4'h0;
    tick();
    chk("m0adv_hold", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_ctl("m0adv_idle", 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("m0adv_stay", 1'b0, 1'b0, 1'b0);

    mask = 4'hF; dwell = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("rst_first", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rst_s1", 2'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rst_s2", 2'd2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1; tick();
    chk("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0; rst = 1'b0;
    chk("rst_over_start", 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_release_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart", 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("restart_adv", 2'd1, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
